// File: rtl/nrs_reader_rx_pkg.sv
// nrs_reader_rx_pkg
//   Shared constants, FSM state type and the QPSK rail mapper for the RX NRS
//   path. The NRS control unit and the channel estimator import it as well.
package nrs_reader_rx_pkg;

    localparam int WIDTH_REG = 16;                 // NRS bits per subframe
    localparam int LINES     = $clog2(WIDTH_REG);  // bank address width
    localparam int NUM_SYM   = WIDTH_REG / 2;      // QPSK symbols per subframe
    localparam int IDX_W     = $clog2(NUM_SYM);
    localparam int AMP_W     = 16;                 // Q1.15 rail width
    localparam logic signed [AMP_W-1:0] AMP = 16'sd23170;  // 1/sqrt2

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_I,
        S_RD_Q,
        S_CAP,
        S_OUT,
        S_ACK
    } state_e;

    // Gold-sequence bit to reference rail: 0 -> +1/sqrt2, 1 -> -1/sqrt2.
    function automatic logic signed [AMP_W-1:0] qpsk_rail(input logic b);
        return b ? -AMP : AMP;
    endfunction

endpackage

// File: rtl/nrs_reader_rx_if.sv
// nrs_reader_rx_if
//   Bus between the NRS reader, the NRS register bank and the estimator.
//   master (reader): rd_en, rd_addr, sym_valid, sym_re, sym_im, sym_idx,
//                    sym_last out; rd_data, sym_ready in.
//   slave (bank + estimator): the mirror image.
interface nrs_reader_rx_if;

    logic                                         rd_en;
    logic [nrs_reader_rx_pkg::LINES-1:0]          rd_addr;
    logic                                         rd_data;
    logic                                         sym_valid;
    logic                                         sym_ready;
    logic signed [nrs_reader_rx_pkg::AMP_W-1:0]   sym_re;
    logic signed [nrs_reader_rx_pkg::AMP_W-1:0]   sym_im;
    logic [nrs_reader_rx_pkg::IDX_W-1:0]          sym_idx;
    logic                                         sym_last;

    modport master (
        output rd_en, rd_addr, sym_valid, sym_re, sym_im, sym_idx, sym_last,
        input  rd_data, sym_ready
    );

    modport slave (
        input  rd_en, rd_addr, sym_valid, sym_re, sym_im, sym_idx, sym_last,
        output rd_data, sym_ready
    );

endinterface

// File: rtl/nrs_reader_rx.sv
// nrs_reader_rx
//   Consumer end of the RX NRS buffer handshake. When the generator flags a
//   fresh set it reads the 16 Gold bits pairwise from the register bank, maps
//   each pair to a QPSK reference symbol, streams the 8 symbols over
//   valid/ready and pulses est_ack_o once the set has been consumed.
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous active-high reset
//   nrs_gen_ready_i  level, bank holds a fresh NRS set
//   flush_i          synchronous abort of the current read-out
//   bus              master side of nrs_reader_rx_if (bank read + symbol stream)
//   est_ack_o        one-cycle pulse, whole set consumed
//   busy_o           FSM not idle
module nrs_reader_rx
    import nrs_reader_rx_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              nrs_gen_ready_i,
    input  logic              flush_i,
    nrs_reader_rx_if.master   bus,
    output logic              est_ack_o,
    output logic              busy_o
);

    state_e                    cs_q;
    logic [IDX_W-1:0]          k_q;
    logic                      armed_q;
    logic                      bit_i_q;
    logic signed [AMP_W-1:0]   sym_re_q;
    logic signed [AMP_W-1:0]   sym_im_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_q     <= S_IDLE;
            k_q      <= '0;
            armed_q  <= 1'b1;
            bit_i_q  <= 1'b0;
            sym_re_q <= '0;
            sym_im_q <= '0;
        end else if (flush_i && cs_q != S_IDLE) begin
            // Abort; armed is left alone so a still-high ready cannot replay the set.
            cs_q <= S_IDLE;
            k_q  <= '0;
        end else begin
            case (cs_q)
                S_IDLE: begin
                    if (nrs_gen_ready_i && armed_q) begin
                        cs_q    <= S_RD_I;
                        k_q     <= '0;
                        armed_q <= 1'b0;
                    end else if (!nrs_gen_ready_i) begin
                        // Generator dropped ready: the next rising ready is a new set.
                        armed_q <= 1'b1;
                    end
                end
                S_RD_I: cs_q <= S_RD_Q;
                S_RD_Q: begin
                    bit_i_q <= bus.rd_data;     // c(2k), read issued in RD_I
                    cs_q    <= S_CAP;
                end
                S_CAP: begin
                    // c(2k+1) arrives this cycle and feeds the Q rail directly.
                    sym_re_q <= qpsk_rail(bit_i_q);
                    sym_im_q <= qpsk_rail(bus.rd_data);
                    cs_q     <= S_OUT;
                end
                S_OUT: begin
                    if (bus.sym_ready) begin
                        if (k_q == IDX_W'(NUM_SYM - 1)) begin
                            cs_q <= S_ACK;
                        end else begin
                            k_q  <= k_q + 1'b1;
                            cs_q <= S_RD_I;
                        end
                    end
                end
                S_ACK: begin
                    k_q  <= '0;
                    cs_q <= S_IDLE;
                end
                default: cs_q <= S_IDLE;
            endcase
        end
    end

    // Moore decode from the state register; sym_ready never reaches these.
    assign bus.rd_en     = (cs_q == S_RD_I) || (cs_q == S_RD_Q);
    assign bus.rd_addr   = (cs_q == S_RD_I) ? {k_q, 1'b0} :
                           (cs_q == S_RD_Q) ? {k_q, 1'b1} : '0;
    assign bus.sym_valid = (cs_q == S_OUT);
    assign bus.sym_re    = sym_re_q;
    assign bus.sym_im    = sym_im_q;
    assign bus.sym_idx   = k_q;
    assign bus.sym_last  = (cs_q == S_OUT) && (k_q == IDX_W'(NUM_SYM - 1));
    // A flush landing on the ACK cycle suppresses the acknowledge.
    assign est_ack_o     = (cs_q == S_ACK) && !flush_i;
    assign busy_o        = (cs_q != S_IDLE);

endmodule
